// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register dump transmitter.
package reg_dump_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StFin
  } state_e;

  // Which part of the frame the current byte comes from
  typedef enum logic [1:0] {
    SrcHeader,
    SrcPc,
    SrcReg
  } src_e;

  localparam logic [7:0]  DefaultHeader = 8'hA5;
  localparam int unsigned FrameBytes    = 130;

endpackage

// File: rtl/reg_dump_tx.sv
// Streams a frame of HEADER, PC and every register word (MSB first) out through a byte UART.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int unsigned       NB_DATA = 32,
  parameter int unsigned       NB_REG  = 5,
  parameter int unsigned       N_BITS  = 8,
  parameter int unsigned       NB_PC   = 7,
  parameter logic [N_BITS-1:0] HEADER  = DefaultHeader
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [NB_PC-1:0]   pc_i,
  output logic [NB_REG-1:0]  reg_addr_o,
  input  logic [NB_DATA-1:0] reg_data_i,
  output logic [N_BITS-1:0]  tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic               busy_o,
  output logic               done_o
);

  state_e              state_q;
  src_e                src_q;
  logic [NB_PC-1:0]    pc_q;
  logic [NB_DATA-1:0]  word_q;
  logic [1:0]          byte_idx_q;
  logic [NB_REG-1:0]   reg_idx_q;
  logic [NB_REG-1:0]   reg_addr_q;
  logic [N_BITS-1:0]   tx_data_q;
  logic                tx_start_q;
  logic                busy_q;
  logic                done_q;

  // 4:1 byte mux, index 0 selects the most significant byte
  function automatic logic [N_BITS-1:0] byte_sel(input logic [NB_DATA-1:0] word,
                                                 input logic [1:0]         idx);
    logic [N_BITS-1:0] b;
    case (idx)
      2'd0:    b = word[NB_DATA-1            -: N_BITS];
      2'd1:    b = word[NB_DATA-1 -   N_BITS -: N_BITS];
      2'd2:    b = word[NB_DATA-1 - 2*N_BITS -: N_BITS];
      default: b = word[NB_DATA-1 - 3*N_BITS -: N_BITS];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      src_q      <= SrcHeader;
      pc_q       <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      reg_idx_q  <= '0;
      reg_addr_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            pc_q       <= pc_i;
            busy_q     <= 1'b1;
            src_q      <= SrcHeader;
            byte_idx_q <= '0;
            reg_idx_q  <= '0;
            reg_addr_q <= '0;
            tx_data_q  <= HEADER;
            tx_start_q <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: state_q <= StWait;
        StWait: begin
          if (tx_done_i) begin
            unique case (src_q)
              SrcHeader: begin
                src_q      <= SrcPc;
                tx_data_q  <= N_BITS'(pc_q);
                tx_start_q <= 1'b1;
                state_q    <= StSend;
              end
              SrcPc: begin
                src_q   <= SrcReg;
                state_q <= StLoad;
              end
              default: begin
                if (byte_idx_q == 2'd3) begin
                  if (&reg_idx_q) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StFin;
                  end else begin
                    reg_idx_q  <= reg_idx_q + 1'b1;
                    reg_addr_q <= reg_idx_q + 1'b1;
                    byte_idx_q <= 2'd0;
                    state_q    <= StLoad;
                  end
                end else begin
                  byte_idx_q <= byte_idx_q + 2'd1;
                  tx_data_q  <= byte_sel(word_q, byte_idx_q + 2'd1);
                  tx_start_q <= 1'b1;
                  state_q    <= StSend;
                end
              end
            endcase
          end
        end
        // Word is latched once here so later bank writes cannot disturb bytes 1..3
        StLoad: begin
          word_q     <= reg_data_i;
          tx_data_q  <= byte_sel(reg_data_i, 2'd0);
          tx_start_q <= 1'b1;
          state_q    <= StSend;
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reg_addr_o = reg_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
